subleq_ctrl: RTL
================

SUBLEQ_CTRL -- requirements
Module: subleq_ctrl

Interface
REQ-001 The module SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter START_PC, default 8'h00: pc value loaded on reset.
REQ-003 Parameter HALT_ADR, default 8'hFF: a taken branch to this address halts the machine.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 run  input  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
REQ-007 ope  output  1  RAM output enable: 0 = enabled, 1 = disabled.
REQ-008 ctl  output  1  RAM direction: 0 = write, 1 = read; the RAM writes on the falling edge of ctl.
REQ-009 ena  output  1  RAM chip enable: 0 = enabled, 1 = disabled.
REQ-010 adr  output  8  RAM address.
REQ-011 dat  inout  8  RAM data; driven only in WS/WP, high-Z otherwise.
REQ-012 pc  output  8  current instruction address.
REQ-013 busy  output  1  1 in any state other than IDLE and HALT.
REQ-014 halted  output  1  1 only in HALT.
REQ-015 icount  output  8  completed instructions, saturating at 8'hFF.

Function
REQ-016 States: IDLE, FA, FB, FC, RA, RB, WS, WP, BR, HALT; ope/ctl/ena/adr/dat-enable SHALL be registered and decoded from the next state, so they are valid for the whole cycle of each state.
REQ-017 IDLE: ope=1, ctl=1, ena=1; run=1 -> FA, otherwise stay.
REQ-018 FA/FB/FC (read pc, pc+1, pc+2 mod 256): ope=0, ctl=1, ena=0; dat sampled at the exit edge into regA/regB/regC respectively.
REQ-019 RA: read adr=regA, sample into opA; RB: read adr=regB, sample into opB.
REQ-020 diff = opB - opA, 8-bit two's complement with wrap; leq = diff[7] OR diff==0.
REQ-021 WS: adr=regB, dat driven with diff, ope=1, ctl=1, ena=0.
REQ-022 WP: adr, dat and ena held; ctl=0, so the falling ctl edge commits mem[regB]=diff with dat stable for one full prior cycle.
REQ-023 BR: ctl=1, ena=1, ope=1, dat released; the pc update at the exit edge is: leq -> pc=regC, else pc=pc+3 mod 256; icount increments unless already 8'hFF.
REQ-024 BR exit: leq AND regC==HALT_ADR -> HALT; else run=1 -> FA; else IDLE.
REQ-025 Each instruction SHALL take exactly 8 cycles (FA..BR); run SHALL be sampled only in IDLE and BR; a deassertion in any other state does not abort the instruction.
REQ-026 HALT: bus idle (ope=1, ctl=1, ena=1, dat Z); run is ignored; only rst exits.
REQ-027 Self-modifying writes, including regB equal to pc, pc+1 or pc+2, SHALL take effect on the next fetch.
REQ-028 ctl SHALL never be 0 while ena=1, and dat SHALL never be driven while ope=0.

Reset
REQ-029 rst=1 SHALL force IDLE, pc=START_PC, icount=0, ope=1, ctl=1, ena=1, dat Z, busy=0, halted=0; internal registers are cleared to 0.
REQ-030 rst asserted in any state, including WS, SHALL return the controller to IDLE at that edge; a write is committed only if WP was entered.

Verification
REQ-031 Reset: assert rst in mid-RB -> next cycle IDLE, pc=00, icount=00, ctl=1, ena=1, ope=1, dat Z.
REQ-032 Negative result: mem[0..2]=10,12,3, mem[10]=3, mem[12]=0, run=1 -> mem[12]=FD, pc=03 after 8 cycles, icount=01.
REQ-033 Positive result: at pc=03, mem[3..5]=12,11,6, mem[11]=2, mem[12]=FD -> mem[11]=05, pc=06.
REQ-034 Wrap: START_PC=FE -> fetches at FE, FF, 00; with a positive result pc=01.
REQ-035 Halt: C=FF with result 0 -> halted=1, busy=0, bus idle, pc=FF, no further RAM access while run=1.
REQ-036 Run drop and reset in WS: run=0 at FB -> instruction completes, IDLE at the BR exit, resumes on run=1; rst in WS -> target RAM location unchanged, ctl never falls.

Source files
------------

// File: rtl/subleq_ctrl.sv
// SUBLEQ controller: fetches A, B, C and computes mem[B] = mem[B] - mem[A].
// It branches to C when the result is <= 0, and otherwise advances pc by 3.
// Bus controls are registered from the next state, so they are stable for the whole state.
module subleq_ctrl #(
    parameter logic [7:0] START_PC = 8'h00,
    parameter logic [7:0] HALT_ADR = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       ope,
    output logic       ctl,
    output logic       ena,
    output logic [7:0] adr,
    inout  wire  [7:0] dat,
    output logic [7:0] pc,
    output logic       busy,
    output logic       halted,
    output logic [7:0] icount
);
    localparam int unsigned W = 8;

    typedef enum logic [3:0] {IDLE, FA, FB, FC, RA, RB, WS, WP, BR, HALT} state_t;

    state_t       state, state_nx;
    logic [W-1:0] reg_a, reg_b, reg_c, op_a, op_b;
    logic [W-1:0] diff, pc_nx, adr_nx;
    logic         leq, ope_nx, ctl_nx, ena_nx, drv, drv_nx;

    assign diff = op_b - op_a;
    assign leq  = diff[W-1] | (diff == '0);
    assign dat  = drv ? diff : {W{1'bz}};

    // Next state, next pc and the bus controls for the state being entered
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ope_nx   = 1'b1;
        ctl_nx   = 1'b1;
        ena_nx   = 1'b1;
        adr_nx   = adr;
        drv_nx   = 1'b0;
        case (state)
            IDLE: if (run) state_nx = FA;
            FA:   state_nx = FB;
            FB:   state_nx = FC;
            FC:   state_nx = RA;
            RA:   state_nx = RB;
            RB:   state_nx = WS;
            WS:   state_nx = WP;
            WP:   state_nx = BR;
            BR: begin
                pc_nx = leq ? reg_c : W'(pc + W'(3));
                if (leq && (reg_c == HALT_ADR)) state_nx = HALT;
                else if (run)                   state_nx = FA;
                else                            state_nx = IDLE;
            end
            HALT:    state_nx = HALT;
            default: state_nx = IDLE;
        endcase
        case (state_nx)
            FA: begin ope_nx = 1'b0; ena_nx = 1'b0; adr_nx = pc_nx; end
            FB: begin ope_nx = 1'b0; ena_nx = 1'b0; adr_nx = W'(pc + W'(1)); end
            FC: begin ope_nx = 1'b0; ena_nx = 1'b0; adr_nx = W'(pc + W'(2)); end
            RA: begin ope_nx = 1'b0; ena_nx = 1'b0; adr_nx = reg_a; end
            RB: begin ope_nx = 1'b0; ena_nx = 1'b0; adr_nx = reg_b; end
            WS: begin ena_nx = 1'b0; adr_nx = reg_b; drv_nx = 1'b1; end
            // ctl falls entering WP; address and data were already stable through WS
            WP: begin ena_nx = 1'b0; ctl_nx = 1'b0; adr_nx = reg_b; drv_nx = 1'b1; end
            default: ;
        endcase
    end

    // State, bus control, status, pc and instruction counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ope    <= 1'b1;
            ctl    <= 1'b1;
            ena    <= 1'b1;
            adr    <= '0;
            drv    <= 1'b0;
            busy   <= 1'b0;
            halted <= 1'b0;
            pc     <= START_PC;
            icount <= '0;
        end else begin
            state  <= state_nx;
            ope    <= ope_nx;
            ctl    <= ctl_nx;
            ena    <= ena_nx;
            adr    <= adr_nx;
            drv    <= drv_nx;
            busy   <= (state_nx != IDLE) && (state_nx != HALT);
            halted <= (state_nx == HALT);
            pc     <= pc_nx;
            if ((state == BR) && (icount != 8'hFF)) icount <= W'(icount + W'(1));
        end
    end

    // Capture read data at the exit edge of each read state
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_a <= '0;
            reg_b <= '0;
            reg_c <= '0;
            op_a  <= '0;
            op_b  <= '0;
        end else begin
            case (state)
                FA:      reg_a <= dat;
                FB:      reg_b <= dat;
                FC:      reg_c <= dat;
                RA:      op_a  <= dat;
                RB:      op_b  <= dat;
                default: ;
            endcase
        end
    end
endmodule
